// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-access stage: RV32I funct3 codes, FSM states,
// store strobe patterns and request legality/encoding helpers.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_e;

  // Illegal width code or an address not aligned to the access size.
  function automatic logic req_illegal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = (funct3 >= 3'b011);
    else    bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_SB:   return STRB_B << off;
      F3_SH:   return STRB_H << {off[1], 1'b0};
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_SB:   return {4{wdata[7:0]}};
      F3_SH:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension of a 32-bit read word.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {offset, 3'b000});
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    value     = '0;
    case (funct3)
      F3_LB:   value = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  value = {24'd0, byte_lane};
      F3_LH:   value = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  value = {16'd0, half_lane};
      F3_LW:   value = rdata;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time over a valid/ready data port,
// registered load writeback with ALU-collision flag.
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            dmem_valid,
  input  logic            dmem_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            alu_to_reg,
  output logic [XLEN-1:0] mem_val,
  output logic            mem_to_reg,
  output logic [4:0]      mem_rd,
  output logic            collision,
  output logic            fault
);

  lsu_state_e      state, state_next;
  logic            bad_req;
  logic            accept;
  logic            lat_we;
  logic [2:0]      lat_funct3;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [3:0]      lat_wstrb;
  logic [4:0]      lat_rd;
  logic [XLEN-1:0] ext_val;

  assign bad_req = req_illegal(req_we, req_funct3, req_addr[1:0]);
  assign accept  = (state == IDLE) && req_valid && !bad_req;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    dmem_valid = 1'b0;
    dmem_we    = 1'b0;
    dmem_wstrb = 4'b0000;
    mem_to_reg = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_next = REQ;
      end
      REQ: begin
        dmem_valid = 1'b1;
        dmem_we    = lat_we;
        dmem_wstrb = lat_we ? lat_wstrb : 4'b0000;
        if (dmem_ready) state_next = lat_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid) state_next = WB;
      end
      WB: begin
        mem_to_reg = (mem_rd != 5'd0);
        state_next = IDLE;
      end
    endcase
  end

  assign dmem_addr  = {lat_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata = lat_wdata;
  assign collision  = mem_to_reg && alu_to_reg;

  load_extend u_extend (
    .rdata  (dmem_rdata),
    .offset (lat_addr[1:0]),
    .funct3 (lat_funct3),
    .value  (ext_val)
  );

  // Control and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fault   <= 1'b0;
      mem_val <= '0;
      mem_rd  <= '0;
    end else begin
      state <= state_next;
      fault <= (state == IDLE) && req_valid && bad_req;
      if ((state == WAIT) && dmem_rvalid) begin
        mem_val <= ext_val;
        mem_rd  <= lat_rd;
      end
    end
  end

  // Request latch: data only, qualified by the FSM
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= store_data(req_funct3, req_wdata);
      lat_wstrb  <= store_strb(req_funct3, req_addr[1:0]);
      lat_rd     <= req_rd;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RISC-V core. Accepts one load/store at a time from execute, drives the data-memory valid/ready port, aligns and sign/zero-extends load data, and presents a registered load result (`mem_val`, `mem_to_reg`, `mem_rd`) to the register-file write arbiter. It raises `collision` whenever its one-cycle load writeback coincides with an ALU writeback, so the arbiter and pipeline can serialize the two writes.

## Interface
- `XLEN`, 32, data/address width (only 32 supported)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  execute presents a memory op
- `req_ready`  out  1  unit can accept (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width/sign field
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (low bytes significant)
- `req_rd`  in  5  load destination register
- `dmem_valid`  out  1  request to data memory
- `dmem_ready`  in  1  memory accepts request
- `dmem_we`, `dmem_addr[31:0]` (word-aligned), `dmem_wdata[31:0]`, `dmem_wstrb[3:0]`  out  request fields
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  32  read word
- `alu_to_reg`  in  1  ALU writes back this cycle
- `mem_val`  out  32  extended load result (registered)
- `mem_to_reg`  out  1  load writeback, one-cycle pulse
- `mem_rd`  out  5  load destination
- `collision`  out  1  `mem_to_reg & alu_to_reg` (combinational)
- `fault`  out  1  one-cycle pulse: misaligned or illegal funct3

## Operation
- FSM states IDLE, REQ, WAIT, WB; reset → IDLE.
- IDLE: `req_ready`=1. On `req_valid`: if halfword addr[0]≠0, word addr[1:0]≠0, or funct3 illegal (load: 011/110/111; store: ≥011) → pulse `fault` next cycle, stay IDLE, no memory access. Else latch op, go REQ.
- REQ: `dmem_valid`=1, fields stable until `dmem_ready`. On handshake: store → IDLE; load → WAIT.
- WAIT: on `dmem_rvalid`, lane-select by addr[1:0], extend (LB/LH sign, LBU/LHU zero, LW pass), register into `mem_val`, go WB.
- WB: `mem_to_reg`=1 for exactly one cycle (0 if `mem_rd`==0), then IDLE.
- Store encoding: `dmem_wstrb` SB = 0001<<off, SH = 0011<<off, SW = 1111; `dmem_wdata` = byte replicated ×4 (SB), half replicated ×2 (SH), word (SW).
- `collision` only while in WB with `alu_to_reg`=1; arbiter writes `mem_val` that cycle, ALU value next cycle. ALU side holds its value; this unit never holds `mem_to_reg` beyond one cycle.
- `dmem_rvalid` outside WAIT ignored.

## Timing
- Reset values: `req_ready`=0 during reset then 1, `dmem_valid`=0, `dmem_we`=0, `dmem_wstrb`=0, `mem_to_reg`=0, `mem_val`=0, `mem_rd`=0, `fault`=0, `collision`=0.
- Accept at cycle N → `dmem_valid` at N+1. Zero-wait memory (ready at N+1, rvalid at N+2) → `mem_to_reg` at N+3.
- Store with ready at N+1 → `req_ready` high again at N+2.
- `fault` at N+1 for faulting request accepted at N; next request acceptable at N+1.
- Reset mid-operation (any state): immediate return to IDLE, outputs to reset values, in-flight response discarded.

## Structure
- Package `riscv_mem_pkg`: funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW), FSM state enum, strobe patterns.
- Sub-module `load_extend`: combinational lane select + sign/zero extend (rdata, offset, funct3 → 32-bit value).

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF, zero-wait → `mem_to_reg` at N+3, `mem_val`=0xDEADBEEF, `mem_rd`=req_rd.
- LB addr 0x103, rdata 0x80FF_0000 → `mem_val`=0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x101 wdata 0x12 → `dmem_wstrb`=0010, `dmem_wdata`=0x12121212, `dmem_addr`=0x100; SH addr 0x102 → wstrb 1100.
- LW addr 0x102 → `fault` pulse, `dmem_valid` never asserts; funct3=011 load → `fault`.
- Load WB with `alu_to_reg`=1 → `collision`=1 for one cycle; `mem_rd`=0 → `mem_to_reg`=0, `collision`=0.
- `dmem_ready` held low 5 cycles then `rst` asserted → `dmem_valid`=0 immediately; late `dmem_rvalid` after reset produces no `mem_to_reg`.
